touch_button_fsm: RTL and testbench

Debounce and gesture stage directly downstream of the touch-region detector. It consumes the per-sample region-hit flag, `td_hit`, and the sample strobe `td_valid`, which marks when `td_hit` is meaningful. From these it produces clean single-cycle press, long-press and release events, a press level, a toggle state and a wrapping press counter. Display and counting logic use these outputs to react to on-screen buttons without chatter from touch-controller noise.

---
 rtl/touch_button_fsm.sv | 161 ++++++++++++++++
 tb/tb_touch_button_fsm.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/touch_button_fsm.sv
// Debounce and gesture FSM for one touch button: turns noisy per-sample region
// hits into clean press / long-press / release events plus level, toggle and counter.
module touch_button_fsm #(
    parameter int unsigned CONFIRM_N = 4,
    parameter int unsigned RELEASE_N = 4,
    parameter int unsigned LONG_N    = 200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       td_valid,
    input  logic       td_hit,
    output logic       pressed,
    output logic       press_pulse,
    output logic       long_pulse,
    output logic       release_pulse,
    output logic       was_long,
    output logic       toggle,
    output logic [7:0] press_cnt
);

    localparam logic [7:0] CONFIRM_C = 8'(CONFIRM_N);
    localparam logic [7:0] RELEASE_C = 8'(RELEASE_N);
    localparam logic [9:0] LONG_C    = 10'(LONG_N);

    typedef enum logic [1:0] {IDLE, ARM, HELD, REL} state_t;

    state_t     state, state_nxt;
    logic [7:0] run_cnt, run_cnt_nxt;
    logic [9:0] hold_cnt, hold_cnt_nxt, hold_inc;
    logic       long_flag, long_flag_nxt;
    logic       pressed_nxt, press_pulse_nxt, long_pulse_nxt, release_pulse_nxt;
    logic       was_long_nxt, toggle_nxt;
    logic [7:0] press_cnt_nxt;
    logic       do_press, do_release, do_long;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            run_cnt       <= '0;
            hold_cnt      <= '0;
            long_flag     <= 1'b0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            long_pulse    <= 1'b0;
            release_pulse <= 1'b0;
            was_long      <= 1'b0;
            toggle        <= 1'b0;
            press_cnt     <= '0;
        end else begin
            state         <= state_nxt;
            run_cnt       <= run_cnt_nxt;
            hold_cnt      <= hold_cnt_nxt;
            long_flag     <= long_flag_nxt;
            pressed       <= pressed_nxt;
            press_pulse   <= press_pulse_nxt;
            long_pulse    <= long_pulse_nxt;
            release_pulse <= release_pulse_nxt;
            was_long      <= was_long_nxt;
            toggle        <= toggle_nxt;
            press_cnt     <= press_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt         = state;
        run_cnt_nxt       = run_cnt;
        hold_cnt_nxt      = hold_cnt;
        long_flag_nxt     = long_flag;
        pressed_nxt       = pressed;
        press_pulse_nxt   = 1'b0;
        long_pulse_nxt    = 1'b0;
        release_pulse_nxt = 1'b0;
        was_long_nxt      = 1'b0;
        toggle_nxt        = toggle;
        press_cnt_nxt     = press_cnt;
        do_press          = 1'b0;
        do_release        = 1'b0;
        do_long           = 1'b0;
        hold_inc          = (hold_cnt == 10'h3FF) ? hold_cnt : hold_cnt + 10'd1;

        if (!en) begin
            state_nxt     = IDLE;
            run_cnt_nxt   = '0;
            hold_cnt_nxt  = '0;
            long_flag_nxt = 1'b0;
            pressed_nxt   = 1'b0;
        end else if (td_valid) begin
            case (state)
                IDLE: begin
                    if (td_hit) begin
                        if (CONFIRM_C == 8'd1) begin
                            do_press = 1'b1;
                        end else begin
                            state_nxt   = ARM;
                            run_cnt_nxt = 8'd1;
                        end
                    end
                end
                ARM: begin
                    if (td_hit) begin
                        if (run_cnt + 8'd1 == CONFIRM_C) do_press = 1'b1;
                        else                             run_cnt_nxt = run_cnt + 8'd1;
                    end else begin
                        state_nxt   = IDLE;
                        run_cnt_nxt = '0;
                    end
                end
                HELD: begin
                    hold_cnt_nxt = hold_inc;
                    if (td_hit) begin
                        do_long = !long_flag && (hold_inc >= LONG_C);
                    end else if (RELEASE_C == 8'd1) begin
                        do_release = 1'b1;
                    end else begin
                        state_nxt   = REL;
                        run_cnt_nxt = 8'd1;
                    end
                end
                REL: begin
                    // Held time keeps running through release glitches; a threshold
                    // crossed during a glitch is honoured on the next hit.
                    hold_cnt_nxt = hold_inc;
                    if (td_hit) begin
                        state_nxt   = HELD;
                        run_cnt_nxt = '0;
                        do_long     = !long_flag && (hold_inc >= LONG_C);
                    end else if (run_cnt + 8'd1 == RELEASE_C) begin
                        do_release = 1'b1;
                    end else begin
                        run_cnt_nxt = run_cnt + 8'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        if (do_press) begin
            state_nxt       = HELD;
            run_cnt_nxt     = '0;
            hold_cnt_nxt    = '0;
            long_flag_nxt   = 1'b0;
            pressed_nxt     = 1'b1;
            press_pulse_nxt = 1'b1;
            toggle_nxt      = ~toggle;
            press_cnt_nxt   = press_cnt + 8'd1;
        end
        if (do_long) begin
            long_flag_nxt  = 1'b1;
            long_pulse_nxt = 1'b1;
        end
        if (do_release) begin
            state_nxt         = IDLE;
            run_cnt_nxt       = '0;
            pressed_nxt       = 1'b0;
            release_pulse_nxt = 1'b1;
            was_long_nxt      = long_flag;
        end
    end

endmodule

// File: tb/tb_touch_button_fsm.sv
// Directed and randomized bench for touch_button_fsm against a streak-counting
// behavioural model of the button gestures.
module tb_touch_button_fsm;

    localparam int CONFIRM_N = 4;
    localparam int RELEASE_N = 4;
    localparam int LONG_N    = 200;

    logic       clk;
    logic       reset;
    logic       en;
    logic       td_valid;
    logic       td_hit;
    logic       pressed;
    logic       press_pulse;
    logic       long_pulse;
    logic       release_pulse;
    logic       was_long;
    logic       toggle;
    logic [7:0] press_cnt;

    touch_button_fsm #(
        .CONFIRM_N(CONFIRM_N),
        .RELEASE_N(RELEASE_N),
        .LONG_N(LONG_N)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .td_valid(td_valid),
        .td_hit(td_hit),
        .pressed(pressed),
        .press_pulse(press_pulse),
        .long_pulse(long_pulse),
        .release_pulse(release_pulse),
        .was_long(was_long),
        .toggle(toggle),
        .press_cnt(press_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int long_seen = 0;

    // Model: streak lengths and held-sample count instead of explicit states.
    int  m_hits, m_misses, m_held, m_cnt;
    bit  m_pressed, m_long_done, m_toggle;
    bit  e_press, e_long, e_rel, e_was_long;

    task automatic model_reset();
        m_hits = 0; m_misses = 0; m_held = 0; m_cnt = 0;
        m_pressed = 0; m_long_done = 0; m_toggle = 0;
        e_press = 0; e_long = 0; e_rel = 0; e_was_long = 0;
    endtask

    task automatic model_step(input bit e, input bit v, input bit h);
        e_press = 0; e_long = 0; e_rel = 0; e_was_long = 0;
        if (!e) begin
            m_hits = 0; m_misses = 0; m_held = 0;
            m_pressed = 0; m_long_done = 0;
        end else if (v) begin
            if (!m_pressed) begin
                if (h) begin
                    m_hits++;
                    if (m_hits == CONFIRM_N) begin
                        m_pressed = 1; m_hits = 0; m_held = 0; m_long_done = 0;
                        m_toggle = ~m_toggle; m_cnt = (m_cnt + 1) % 256;
                        e_press = 1;
                    end
                end else begin
                    m_hits = 0;
                end
            end else begin
                if (m_held < 1023) m_held++;
                if (h) begin
                    m_misses = 0;
                    if (!m_long_done && m_held >= LONG_N) begin
                        m_long_done = 1; e_long = 1;
                    end
                end else begin
                    m_misses++;
                    if (m_misses == RELEASE_N) begin
                        m_pressed = 0; m_misses = 0;
                        e_rel = 1; e_was_long = m_long_done;
                    end
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("pressed", {9'd0, pressed}, {9'd0, m_pressed});
        check("press_pulse", {9'd0, press_pulse}, {9'd0, e_press});
        check("long_pulse", {9'd0, long_pulse}, {9'd0, e_long});
        check("release_pulse", {9'd0, release_pulse}, {9'd0, e_rel});
        check("was_long", {9'd0, was_long}, {9'd0, e_was_long});
        check("toggle", {9'd0, toggle}, {9'd0, m_toggle});
        check("press_cnt", {2'd0, press_cnt}, 10'(m_cnt));
        check("pulse_exclusive", {9'd0, press_pulse & release_pulse}, 10'd0);
        if (long_pulse === 1'b1) long_seen++;
    endtask

    task automatic step(input bit e, input bit v, input bit h);
        en = e; td_valid = v; td_hit = h;
        @(posedge clk);
        model_step(e, v, h);
        #1;
        check_all();
    endtask

    task automatic sample(input bit h, input int gap);
        repeat (gap) step(1'b1, 1'b0, 1'($urandom));
        step(1'b1, 1'b1, h);
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic press_now();
        repeat (CONFIRM_N) step(1'b1, 1'b1, 1'b1);
    endtask

    initial begin
        bit lvl;
        bit re, rv, rh;
        reset = 1'b0; en = 1'b0; td_valid = 1'b0; td_hit = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        reset = 1'b1;

        // Basic press/release with sparse samples
        for (int i = 0; i < 4; i++) sample(1'b1, 7);
        check("t1_press_pulse", {9'd0, press_pulse}, 10'd1);
        check("t1_press_cnt", {2'd0, press_cnt}, 10'd1);
        check("t1_toggle", {9'd0, toggle}, 10'd1);
        for (int i = 0; i < 3; i++) sample(1'b0, 7);
        check("t1_no_early_release", {9'd0, release_pulse}, 10'd0);
        sample(1'b0, 7);
        check("t1_release_pulse", {9'd0, release_pulse}, 10'd1);
        check("t1_was_long", {9'd0, was_long}, 10'd0);
        check("t1_pressed_low", {9'd0, pressed}, 10'd0);

        // Interrupted hit run
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1);
        check("t2_no_press_yet", {9'd0, press_pulse}, 10'd0);
        step(1'b1, 1'b1, 1'b1);
        check("t2_press_pulse", {9'd0, press_pulse}, 10'd1);
        check("t2_press_cnt", {2'd0, press_cnt}, 10'd1);

        // Long press fires once, then release reports it
        do_reset();
        press_now();
        long_seen = 0;
        for (int i = 0; i < LONG_N - 1; i++) step(1'b1, 1'b1, 1'b1);
        check("t3_no_long_before", 10'(long_seen), 10'd0);
        step(1'b1, 1'b1, 1'b1);
        check("t3_long_pulse", {9'd0, long_pulse}, 10'd1);
        for (int i = 0; i < 300; i++) step(1'b1, 1'b1, 1'b1);
        check("t3_long_once", 10'(long_seen), 10'd1);
        repeat (RELEASE_N) step(1'b1, 1'b1, 1'b0);
        check("t3_release_pulse", {9'd0, release_pulse}, 10'd1);
        check("t3_was_long", {9'd0, was_long}, 10'd1);

        // Release glitch keeps the press alive
        do_reset();
        press_now();
        repeat (5) step(1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b1, 1'b0);
        check("t4_pressed_in_glitch", {9'd0, pressed}, 10'd1);
        step(1'b1, 1'b1, 1'b1);
        repeat (3) step(1'b1, 1'b1, 1'b0);
        check("t4_no_release_yet", {9'd0, release_pulse}, 10'd0);
        step(1'b1, 1'b1, 1'b0);
        check("t4_release_pulse", {9'd0, release_pulse}, 10'd1);

        // Counter wrap over 256 presses
        do_reset();
        for (int i = 0; i < 256; i++) begin
            press_now();
            repeat (RELEASE_N) step(1'b1, 1'b1, 1'b0);
        end
        check("t5_cnt_wrap", {2'd0, press_cnt}, 10'd0);
        check("t5_toggle_even", {9'd0, toggle}, 10'd0);

        // Enable drop while held
        do_reset();
        press_now();
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        check("t6_en_pressed", {9'd0, pressed}, 10'd0);
        check("t6_en_no_release", {9'd0, release_pulse}, 10'd0);
        check("t6_en_cnt_kept", {2'd0, press_cnt}, 10'd1);
        check("t6_en_toggle_kept", {9'd0, toggle}, 10'd1);

        // Reset mid-press
        press_now();
        check("t6_repressed", {9'd0, pressed}, 10'd1);
        do_reset();
        check("t6_rst_pressed", {9'd0, pressed}, 10'd0);
        check("t6_rst_cnt", {2'd0, press_cnt}, 10'd0);

        // Randomized noisy touch activity
        lvl = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 249) == 0) lvl = ~lvl;
            re = ($urandom_range(0, 999) != 0);
            rv = ($urandom_range(0, 3) != 0);
            rh = ($urandom_range(0, 19) == 0) ? ~lvl : lvl;
            step(re, rv, rh);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
